// File: rtl/sqrt2_host_pkg.sv
// sqrt2_host_pkg: shared state type and constants for the sqrt2 host sequencer.
package sqrt2_host_pkg;

  localparam int HALF_W = 16;

  // Quiet NaN returned when the core never answers.
  localparam logic [HALF_W-1:0] QNAN_TMO = 16'hFE00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [HALF_W-1:0] sat_inc(input logic [HALF_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sqrt2_host_ctrl_bus_drv.sv
// sqrt2_bus_drv: registered tri-state driver for the sqrt2 IO_DATA bus.
// The drive enable is a flop so the bus turns around on clock edges only,
// and reset releases the bus immediately.
module sqrt2_bus_drv
  import sqrt2_host_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [HALF_W-1:0] i_data,
  input  logic              i_drive_en,
  inout  wire  [HALF_W-1:0] io_bus
);

  logic              r_oe;
  logic [HALF_W-1:0] r_data;

  // Drive-enable flop; asynchronous reset releases the bus at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_oe <= 1'b0;
    else          r_oe <= i_drive_en;
  end

  // Operand holding register, loaded when a request is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_data <= '0;
    else if (i_load) r_data <= i_data;
  end

  assign io_bus = r_oe ? r_data : {HALF_W{1'bz}};

endmodule

// File: rtl/sqrt2_host_ctrl.sv
// sqrt2_host_ctrl: request/response sequencer for the sqrt2 square-root core.
// Optional statistics outputs are enabled with the macro SQRT2_HOST_STATS_EN.
module sqrt2_host_ctrl
  import sqrt2_host_pkg::*;
#(
  parameter int DRIVE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int GAP_CYCLES     = 2,
  parameter int CNT_W          = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [HALF_W-1:0] REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [HALF_W-1:0] RSP_DATA,
  output logic              RSP_NAN,
  output logic              RSP_PINF,
  output logic              RSP_NINF,
  output logic              RSP_TIMEOUT,
  inout  wire  [HALF_W-1:0] SQ_IO_DATA,
  output logic              SQ_ENABLE,
  input  logic              SQ_RESULT,
  input  logic              SQ_IS_NAN,
  input  logic              SQ_IS_PINF,
  input  logic              SQ_IS_NINF,
`ifdef SQRT2_HOST_STATS_EN
  output logic [HALF_W-1:0] STAT_DONE,
  output logic [HALF_W-1:0] STAT_TMO,
  output logic [HALF_W-1:0] STAT_NAN,
`endif
  output logic              BUSY
);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_sq_enable, w_sq_enable_next;
  logic              r_req_ready, w_req_ready_next;
  logic              r_rsp_valid, w_rsp_valid_next;
  logic [HALF_W-1:0] r_rsp_data, w_rsp_data_next;
  logic              r_rsp_nan, w_rsp_nan_next;
  logic              r_rsp_pinf, w_rsp_pinf_next;
  logic              r_rsp_ninf, w_rsp_ninf_next;
  logic              r_rsp_tmo, w_rsp_tmo_next;
  logic              r_busy, w_busy_next;
  logic              w_accept, w_capture, w_timeout, w_drive_en;

  // A request is taken only in IDLE with no response still outstanding.
  assign w_accept  = (r_state == IDLE) && REQ_VALID && r_req_ready;
  assign w_capture = (r_state == WAIT) && SQ_RESULT;
  assign w_timeout = (r_state == WAIT) && !SQ_RESULT &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state, counter, enable and response-register logic.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_sq_enable_next = r_sq_enable;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_nan_next   = r_rsp_nan;
    w_rsp_pinf_next  = r_rsp_pinf;
    w_rsp_ninf_next  = r_rsp_ninf;
    w_rsp_tmo_next   = r_rsp_tmo;

    // The consumer may take the response in any state.
    if (r_rsp_valid && RSP_READY) w_rsp_valid_next = 1'b0;

    case (r_state)
      IDLE: begin
        w_sq_enable_next = 1'b0;
        if (w_accept) begin
          w_state_next     = DRIVE;
          w_cnt_next       = '0;
          w_sq_enable_next = 1'b1;
        end
      end
      DRIVE: begin
        w_sq_enable_next = 1'b1;
        if (r_cnt == CNT_W'(DRIVE_CYCLES - 1)) begin
          w_state_next = WAIT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WAIT: begin
        w_sq_enable_next = 1'b1;
        w_cnt_next       = r_cnt + 1'b1;
        if (w_capture) begin
          w_state_next     = HOLD;
          w_rsp_valid_next = 1'b1;
          w_rsp_data_next  = SQ_IO_DATA;
          w_rsp_nan_next   = SQ_IS_NAN;
          w_rsp_pinf_next  = SQ_IS_PINF;
          w_rsp_ninf_next  = SQ_IS_NINF;
          w_rsp_tmo_next   = 1'b0;
        end else if (w_timeout) begin
          w_state_next     = HOLD;
          w_rsp_valid_next = 1'b1;
          w_rsp_data_next  = QNAN_TMO;
          w_rsp_nan_next   = 1'b0;
          w_rsp_pinf_next  = 1'b0;
          w_rsp_ninf_next  = 1'b0;
          w_rsp_tmo_next   = 1'b1;
        end
      end
      HOLD: begin
        // ENABLE stays high through HOLD and drops on the way into GAP.
        w_sq_enable_next = 1'b0;
        w_state_next     = GAP;
        w_cnt_next       = '0;
      end
      GAP: begin
        w_sq_enable_next = 1'b0;
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next     = IDLE;
        w_cnt_next       = '0;
        w_sq_enable_next = 1'b0;
      end
    endcase

    w_req_ready_next = (w_state_next == IDLE) && !w_rsp_valid_next;
    w_busy_next      = (w_state_next != IDLE);
  end

  assign w_drive_en = (w_state_next == DRIVE);

  // State, counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sq_enable <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_nan   <= 1'b0;
      r_rsp_pinf  <= 1'b0;
      r_rsp_ninf  <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_sq_enable <= w_sq_enable_next;
      r_req_ready <= w_req_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rsp_nan   <= w_rsp_nan_next;
      r_rsp_pinf  <= w_rsp_pinf_next;
      r_rsp_ninf  <= w_rsp_ninf_next;
      r_rsp_tmo   <= w_rsp_tmo_next;
      r_busy      <= w_busy_next;
    end
  end

  sqrt2_bus_drv u_drv (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_load     (w_accept),
    .i_data     (REQ_DATA),
    .i_drive_en (w_drive_en),
    .io_bus     (SQ_IO_DATA)
  );

`ifdef SQRT2_HOST_STATS_EN
  logic [HALF_W-1:0] r_stat_done, r_stat_tmo, r_stat_nan;

  // Saturating event counters, stepped on the capture edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stat_done <= '0;
      r_stat_tmo  <= '0;
      r_stat_nan  <= '0;
    end else begin
      if (w_capture) begin
        r_stat_done <= sat_inc(r_stat_done);
        if (SQ_IS_NAN) r_stat_nan <= sat_inc(r_stat_nan);
      end
      if (w_timeout) r_stat_tmo <= sat_inc(r_stat_tmo);
    end
  end

  assign STAT_DONE = r_stat_done;
  assign STAT_TMO  = r_stat_tmo;
  assign STAT_NAN  = r_stat_nan;
`endif

  assign REQ_READY   = r_req_ready;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_DATA    = r_rsp_data;
  assign RSP_NAN     = r_rsp_nan;
  assign RSP_PINF    = r_rsp_pinf;
  assign RSP_NINF    = r_rsp_ninf;
  assign RSP_TIMEOUT = r_rsp_tmo;
  assign SQ_ENABLE   = r_sq_enable;
  assign BUSY        = r_busy;

endmodule

// File: tb/tb_sqrt2_host_ctrl.sv
// tb_sqrt2_host_ctrl: bench for the sqrt2 host sequencer with a behavioural
// sqrt2 core stub and a response scoreboard.
`timescale 1ns/1ps
module tb_sqrt2_host_ctrl;

  localparam int DRIVE_CYC = 2;
  localparam int TMO_CYC   = 100;
  localparam int GAP_CYC   = 2;

  typedef struct {
    logic [15:0] op;
    logic [15:0] data;
    logic        nan;
    logic        pinf;
    logic        ninf;
    int          lat;
    logic        never;
  } cfg_t;

  typedef struct {
    logic [15:0] data;
    logic        nan;
    logic        pinf;
    logic        ninf;
    logic        tmo;
  } rsp_t;

  typedef struct {
    cfg_t c;
    rsp_t e;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic [15:0] REQ_DATA = 16'h0;
  logic        RSP_READY = 1'b0;
  logic        SQ_RESULT = 1'b0;
  logic        SQ_IS_NAN = 1'b0;
  logic        SQ_IS_PINF = 1'b0;
  logic        SQ_IS_NINF = 1'b0;
  logic        REQ_READY, RSP_VALID, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT;
  logic        SQ_ENABLE, BUSY;
  logic [15:0] RSP_DATA;
  wire  [15:0] SQ_IO_DATA;
`ifdef SQRT2_HOST_STATS_EN
  logic [15:0] STAT_DONE, STAT_TMO, STAT_NAN;
`endif

  logic        stub_oe = 1'b0;
  logic [15:0] stub_data = 16'h0;
  assign SQ_IO_DATA = stub_oe ? stub_data : 16'hzzzz;

  wire dut_oe = dut.u_drv.r_oe;

  sqrt2_host_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_NAN(RSP_NAN), .RSP_PINF(RSP_PINF), .RSP_NINF(RSP_NINF),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .SQ_IO_DATA(SQ_IO_DATA), .SQ_ENABLE(SQ_ENABLE), .SQ_RESULT(SQ_RESULT),
    .SQ_IS_NAN(SQ_IS_NAN), .SQ_IS_PINF(SQ_IS_PINF), .SQ_IS_NINF(SQ_IS_NINF),
`ifdef SQRT2_HOST_STATS_EN
    .STAT_DONE(STAT_DONE), .STAT_TMO(STAT_TMO), .STAT_NAN(STAT_NAN),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;
  int m_done   = 0;
  int m_tmo    = 0;
  int m_nan    = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  cfg_t cfg_q[$];
  rsp_t exp_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic void fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endfunction

  function automatic logic [31:0] pack_rsp(input rsp_t r);
    return {12'h0, r.data, r.nan, r.pinf, r.ninf, r.tmo};
  endfunction

  // Reference behaviour: pass the core's answer through, or the timeout NaN.
  function automatic rsp_t model_rsp(input cfg_t c);
    rsp_t r;
    if (c.never) r = '{16'hFE00, 1'b0, 1'b0, 1'b0, 1'b1};
    else         r = '{c.data, c.nan, c.pinf, c.ninf, 1'b0};
    return r;
  endfunction

  // Response-ready driver.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      case (rdy_mode)
        0:       RSP_READY = 1'b1;
        1:       RSP_READY = 1'($urandom_range(0, 1));
        default: RSP_READY = 1'b0;
      endcase
    end
  end

  // Behavioural sqrt2 core stub: watches the operand phase, then answers
  // after the configured latency (or never).
  int   stub_phase = 0;
  int   stub_k = 0;
  int   stub_dcnt = 0;
  cfg_t stub_cur;
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        stub_phase = 0;
        stub_oe = 1'b0;
        SQ_RESULT = 1'b0;
        {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF} = 3'b000;
      end else begin
        case (stub_phase)
          0: if (dut_oe) begin
            if (cfg_q.size() > 0) begin
              stub_cur = cfg_q.pop_front();
            end else begin
              fail_bound("unexpected_drive");
              stub_cur = '{16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
            end
            check("drive_data", 32'(SQ_IO_DATA), 32'(stub_cur.op));
            check("drive_enable", 32'(SQ_ENABLE), 32'd1);
            stub_dcnt = 1;
            stub_phase = 1;
          end
          1: if (dut_oe) begin
            stub_dcnt++;
          end else begin
            check("drive_cycles", 32'(stub_dcnt), 32'(DRIVE_CYC));
            check("wait_enable", 32'(SQ_ENABLE), 32'd1);
            stub_k = 0;
            if (!stub_cur.never && stub_cur.lat == 0) begin
              stub_oe = 1'b1; stub_data = stub_cur.data; SQ_RESULT = 1'b1;
              {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF} = {stub_cur.nan, stub_cur.pinf, stub_cur.ninf};
            end
            stub_phase = 2;
          end
          2: begin
            stub_k++;
            if (SQ_RESULT) begin
              stub_oe = 1'b0; SQ_RESULT = 1'b0;
              {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF} = 3'b000;
            end
            if (RSP_VALID) begin
              check("rsp_latency", 32'(stub_k), stub_cur.never ? 32'(TMO_CYC) : 32'(stub_cur.lat + 1));
              check("hold_enable", 32'(SQ_ENABLE), 32'd1);
              check("hold_bus_released", 32'(dut_oe), 32'd0);
              stub_phase = 3;
            end else if (!stub_cur.never && stub_k == stub_cur.lat) begin
              stub_oe = 1'b1; stub_data = stub_cur.data; SQ_RESULT = 1'b1;
              {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF} = {stub_cur.nan, stub_cur.pinf, stub_cur.ninf};
            end else if (stub_k > 300) begin
              fail_bound("rsp_wait");
              stub_phase = 0;
            end
          end
          default: begin
            check("gap_enable", 32'(SQ_ENABLE), 32'd0);
            check("gap_bus_released", 32'(dut_oe), 32'd0);
            stub_phase = 0;
          end
        endcase
      end
    end
  end

  // ENABLE low-time between operations.
  initial begin
    int  run;
    bit  armed;
    run = 0;
    armed = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        armed = 0; run = 0;
      end else if (SQ_ENABLE) begin
        if (armed && run > 0) check("gap_low_cycles_ge2", 32'(run >= GAP_CYC), 32'd1);
        armed = 1; run = 0;
      end else if (armed) begin
        run++;
      end
    end
  end

  // Response scoreboard: compares at each handshake, checks stability while stalled.
  initial begin
    bit   held;
    rsp_t hr, e, a;
    held = 0;
    forever begin
      @(negedge CLK);
      a = '{RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT};
      if (!RST_N) begin
        held = 0;
      end else if (RSP_VALID) begin
        if (held) check("rsp_stable", pack_rsp(a), pack_rsp(hr));
        if (RSP_READY) begin
          if (exp_q.size() == 0) begin
            fail_bound("rsp_unexpected");
          end else begin
            e = exp_q.pop_front();
            n_rsp++;
            $display("rsp %0d: data=%h nan=%b pinf=%b ninf=%b tmo=%b", n_rsp,
                     RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT);
            check("rsp_fields", pack_rsp(a), pack_rsp(e));
          end
          held = 0;
        end else begin
          held = 1; hr = a;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic wait_accept();
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge CLK);
      if (REQ_READY) begin
        @(posedge CLK);
        #2;
        REQ_VALID = 1'b0;
        done = 1;
      end else begin
        n++;
        if (n > 1000) begin
          fail_bound("req_accept");
          REQ_VALID = 1'b0;
          done = 1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((BUSY || RSP_VALID || exp_q.size() != 0) && n < 2000);
    if (n >= 2000) fail_bound("idle");
  endtask

  task automatic queue_op(input cfg_t c, input rsp_t e);
    cfg_q.push_back(c);
    exp_q.push_back(e);
    if (c.never) m_tmo++;
    else begin
      m_done++;
      if (c.nan) m_nan++;
    end
  endtask

  task automatic present(input logic [15:0] op);
    @(posedge CLK);
    #2;
    REQ_DATA = op;
    REQ_VALID = 1'b1;
  endtask

  task automatic do_op(input cfg_t c, input rsp_t e);
    queue_op(c, e);
    present(c.op);
    wait_accept();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];
  cfg_t c;
  rsp_t e;
  bit   saw_ready;

  initial begin
    // {op, core data, nan, pinf, ninf, latency, never}, {expected rsp}
    vecs[0] = '{'{16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, 0, 1'b0}, '{16'h4000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{'{16'hFC00, 16'hFE00, 1'b1, 1'b0, 1'b0, 2, 1'b0}, '{16'hFE00, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{'{16'h7C00, 16'h7C00, 1'b0, 1'b1, 1'b0, 1, 1'b0}, '{16'h7C00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{'{16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0, 3, 1'b0}, '{16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{'{16'h4200, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 1'b1}, '{16'hFE00, 1'b0, 1'b0, 1'b0, 1'b1}};

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check("reset_req_ready", 32'(REQ_READY), 32'd0);
    check("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("reset_sq_enable", 32'(SQ_ENABLE), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_bus_released", 32'(dut_oe), 32'd0);
    check("reset_rsp_fields", {11'h0, RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", 32'(REQ_READY), 32'd1);

    // Directed vectors.
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].c, vecs[i].e);
      wait_idle();
    end
`ifdef SQRT2_HOST_STATS_EN
    check("stat_done_directed", 32'(STAT_DONE), 32'd4);
    check("stat_nan_directed", 32'(STAT_NAN), 32'd1);
    check("stat_tmo_directed", 32'(STAT_TMO), 32'd1);
`endif

    // Reset pulsed while the core is being waited on.
    c = '{16'h4A00, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
    do_op(c, model_rsp(c));
    repeat (8) @(posedge CLK);
    #3;
    check("pre_reset_enable", 32'(SQ_ENABLE), 32'd1);
    RST_N = 1'b0;
    #1;
    check("midop_reset_enable", 32'(SQ_ENABLE), 32'd0);
    check("midop_reset_bus", 32'(dut_oe), 32'd0);
    check("midop_reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("midop_reset_busy", 32'(BUSY), 32'd0);
    cfg_q.delete();
    exp_q.delete();
    m_done = 0; m_tmo = 0; m_nan = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    do_op('{16'h4C00, 16'h4400, 1'b0, 1'b0, 1'b0, 1, 1'b0}, '{16'h4400, 1'b0, 1'b0, 1'b0, 1'b0});
    wait_idle();

    // Back-pressure: second request must wait for the first response.
    rdy_mode = 2;
    queue_op('{16'h3400, 16'h3800, 1'b0, 1'b0, 1'b0, 1, 1'b0}, '{16'h3800, 1'b0, 1'b0, 1'b0, 1'b0});
    queue_op('{16'h5400, 16'h4800, 1'b0, 1'b0, 1'b0, 2, 1'b0}, '{16'h4800, 1'b0, 1'b0, 1'b0, 1'b0});
    present(16'h3400);
    wait_accept();
    present(16'h5400);
    saw_ready = 0;
    repeat (20) begin
      @(negedge CLK);
      if (REQ_READY) saw_ready = 1;
    end
    check("bp_req_ready_low", 32'(saw_ready), 32'd0);
    check("bp_first_pending", {15'h0, RSP_VALID, RSP_DATA}, {15'h0, 1'b1, 16'h3800});
    rdy_mode = 0;
    wait_accept();
    wait_idle();

    // Randomized traffic against the pass-through/timeout model.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      c.op    = 16'($urandom);
      c.data  = 16'($urandom);
      c.nan   = 1'($urandom_range(0, 1));
      c.pinf  = 1'($urandom_range(0, 1));
      c.ninf  = 1'($urandom_range(0, 1));
      c.lat   = int'($urandom_range(0, 6));
      c.never = ($urandom_range(0, 9) == 0);
      e = model_rsp(c);
      do_op(c, e);
    end
    rdy_mode = 0;
    wait_idle();
`ifdef SQRT2_HOST_STATS_EN
    check("stat_done_final", 32'(STAT_DONE), 32'(m_done));
    check("stat_nan_final", 32'(STAT_NAN), 32'(m_nan));
    check("stat_tmo_final", 32'(STAT_TMO), 32'(m_tmo));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sqrt2_host_ctrl.md
Name: sqrt2_host_ctrl

Overview:
Upstream sequencer for the sqrt2 half-precision square-root core. It accepts operands on a valid/ready request port and runs the sqrt2 bus protocol: drives IO_DATA, holds ENABLE, releases the bus, waits for RESULT, then captures the result and flags. Results are returned on a valid/ready response port. It sits between the system request stream and the sqrt2 instance; this block is the only driver of sqrt2 ENABLE and of the operand side of IO_DATA.

Parameters:
DRIVE_CYCLES, 2, clock edges for which the operand is driven onto SQ_IO_DATA with SQ_ENABLE high.
TIMEOUT_CYCLES, 100, maximum WAIT cycles before the operation is abandoned.
GAP_CYCLES, 2, cycles SQ_ENABLE is held low after each operation, before the next request is accepted.
CNT_W, 7, width of the shared cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
REQ_VALID  in  1  operand valid.
REQ_READY  out  1  block can accept an operand.
REQ_DATA  in  16  binary16 operand.
RSP_VALID  out  1  response valid.
RSP_READY  in  1  consumer accepts the response.
RSP_DATA  out  16  binary16 result.
RSP_NAN / RSP_PINF / RSP_NINF  out  1 each  captured flags.
RSP_TIMEOUT  out  1  core never raised RESULT.
SQ_IO_DATA  inout  16  tri-state bus to sqrt2 IO_DATA.
SQ_ENABLE  out  1  to sqrt2 ENABLE.
SQ_RESULT  in  1  from sqrt2 RESULT.
SQ_IS_NAN / SQ_IS_PINF / SQ_IS_NINF  in  1 each  from sqrt2 flags.
BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock (CLK). RST_N is asynchronous, active-low. While RST_N is low, all outputs are 0, SQ_IO_DATA is 16'hzzzz, the state is IDLE and the counter is 0. This holds even when reset is asserted mid-operation; any pending response is discarded.
- Outputs: all outputs are registered. The SQ_IO_DATA drive-enable is a flop.
- Main path: IDLE -> DRIVE -> WAIT -> HOLD -> GAP -> IDLE.
- IDLE: REQ_READY = !RSP_VALID.
  - The request is accepted when REQ_VALID && REQ_READY at a rising edge. The operand is latched.
  - Next cycle: SQ_ENABLE=1, the bus is driven with the operand, counter = 0, state goes to DRIVE.
- DRIVE: bus driven and SQ_ENABLE=1 for exactly DRIVE_CYCLES edges. Then the bus is released (z) and state goes to WAIT with counter = 0.
- WAIT: SQ_ENABLE stays 1 and the counter increments each edge.
  - If SQ_RESULT=1 at an edge: capture SQ_IO_DATA and the three flags into the response register, set RSP_VALID=1 and RSP_TIMEOUT=0, go to HOLD.
  - Else, if counter == TIMEOUT_CYCLES-1: RSP_DATA=16'hFE00, all flags 0, RSP_TIMEOUT=1, RSP_VALID=1, go to HOLD.
- HOLD: one cycle with SQ_ENABLE=1, then go to GAP.
- GAP: SQ_ENABLE=0 for GAP_CYCLES edges, then go to IDLE.
- Response handshake: RSP_VALID falls on the edge where RSP_VALID && RSP_READY. This can happen in any state. RSP_* fields are stable while RSP_VALID is high and unaccepted.
- Back-pressure: a new request is not accepted while the previous response is pending. If RSP_READY stays low, the block waits in IDLE with REQ_READY=0.
- Minimum operation: request to RSP_VALID takes 1 + DRIVE_CYCLES + (WAIT cycles until RESULT) edges.
- Bus contention: the block never drives SQ_IO_DATA in WAIT, HOLD, GAP or IDLE.
- Flags are passed through as-is. No result post-processing is done.

Optional Feature:
- Macro: SQRT2_HOST_STATS_EN.
- When defined, three extra outputs are added:
  - STAT_DONE[15:0]: responses captured via RESULT.
  - STAT_TMO[15:0]: timeouts.
  - STAT_NAN[15:0]: responses with NAN set.
- The counters saturate at 16'hFFFF, reset to 0 on RST_N, and increment on the capture edge.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package sqrt2_host_pkg holds:
  - the state enum (IDLE, DRIVE, WAIT, HOLD, GAP);
  - the constant QNAN_TMO = 16'hFE00;
  - the constant HALF_W = 16.
- One sub-module, sqrt2_bus_drv: registered 16-bit tri-state driver with a drive-enable input and an asynchronous-reset release.

Test Plan:
- Request 16'h4400, RSP_READY=1 -> SQ_ENABLE high, bus driven exactly 2 edges then z; RSP_DATA=16'h4000, all flags 0, RSP_TIMEOUT=0.
- Request 16'hFC00 -> RSP_DATA=16'hFE00, RSP_NAN=1. Request 16'h7C00 -> RSP_DATA=16'h7C00, RSP_PINF=1.
- Back-to-back requests 16'h3400 then 16'h5400 with RSP_READY low for 20 cycles -> REQ_READY=0 until the first response (16'h3800) is accepted; second result 16'h4800; SQ_ENABLE low for 2 cycles between operations.
- Core stub never raises RESULT -> RSP_VALID exactly 100 WAIT cycles after DRIVE; RSP_DATA=16'hFE00, RSP_TIMEOUT=1.
- RST_N pulsed low during WAIT -> same-cycle SQ_ENABLE=0, bus z, RSP_VALID=0; the next request 16'h4C00 completes with 16'h4400.
- With SQRT2_HOST_STATS_EN: run 3 good operations, 1 NaN operation, 1 timeout -> STAT_DONE=4, STAT_NAN=1, STAT_TMO=1.
